// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the sum_acc burst accumulator.
package sum_acc_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 64;
    localparam int DEF_CW = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/sum_acc_if.sv
// Beat input and burst-result output of the accumulator, grouped as one bundle.
interface sum_acc_if
    import sum_acc_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int CW = DEF_CW
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] len;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    modport master (
        output in_valid, in_data, len, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, len, flush, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/sum_acc_dp.sv
// Accumulator datapath: zero-extending AW-bit adder with carry-out, sticky
// overflow and beat counter. Load starts a burst, add extends it.
module sum_acc_dp #(
    parameter int DW = 32,
    parameter int AW = 64,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          add,
    input  logic [DW-1:0] data,
    output logic [AW-1:0] acc,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_inc,
    output logic          ovf
);
    logic [AW-1:0] data_ext;
    logic [AW:0]   sum_ext;

    assign data_ext  = {{(AW-DW){1'b0}}, data};
    assign sum_ext   = {1'b0, acc} + {1'b0, data_ext};
    assign count_inc = count + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            acc   <= data_ext;
            count <= CW'(1);
            ovf   <= 1'b0;
        end else if (add) begin
            acc   <= sum_ext[AW-1:0];
            count <= count_inc;
            ovf   <= ovf | sum_ext[AW];
        end
    end
endmodule

// File: rtl/sum_acc.sv
// Burst accumulator: sums a programmable number of DW-bit beats into an
// AW-bit total and offers one result per burst on a valid/ready output.
module sum_acc
    import sum_acc_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int CW = DEF_CW
) (
    input logic     clk,
    input logic     rst,
    sum_acc_if.slave bus
);
    state_t        state;
    logic [CW-1:0] len_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          accept;
    logic          load;
    logic          add;
    logic [AW-1:0] acc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic          ovf;

    assign accept = bus.in_valid && in_ready_q;
    assign load   = accept && (state == IDLE);
    assign add    = accept && (state == ACC);

    sum_acc_dp #(
        .DW(DW),
        .AW(AW),
        .CW(CW)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .add       (add),
        .data      (bus.in_data),
        .acc       (acc),
        .count     (count),
        .count_inc (count_inc),
        .ovf       (ovf)
    );

    // in_ready is registered from the next state, so it never depends on out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        len_q <= bus.len;
                        if (bus.len <= CW'(1) || bus.flush) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (bus.flush || (accept && count_inc == len_q)) begin
                        state       <= DONE;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc;
    assign bus.out_count = count;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_sum_acc.sv
// Directed bench for sum_acc: expected burst results are queued as stimulus is
// issued and popped by monitors on every output handshake.
module tb_sum_acc;
    typedef struct packed {
        logic [63:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t q64[$];
    exp_t q33[$];

    sum_acc_if #(.DW(32), .AW(64), .CW(8)) b64 ();
    sum_acc_if #(.DW(32), .AW(33), .CW(8)) b33 ();

    sum_acc #(.DW(32), .AW(64), .CW(8)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (b64)
    );

    sum_acc #(.DW(32), .AW(33), .CW(8)) dut33 (
        .clk (clk),
        .rst (rst),
        .bus (b33)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && b64.out_valid && b64.out_ready) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result64: got sum 0x%0h, expected no result", b64.out_sum);
            end else begin
                exp_t e;
                e = q64.pop_front();
                chk("sum64", b64.out_sum, e.sum);
                chk("count64", {56'd0, b64.out_count}, {56'd0, e.cnt});
                chk("ovf64", {63'd0, b64.out_ovf}, {63'd0, e.ovf});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b33.out_valid && b33.out_ready) begin
            if (q33.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result33: got sum 0x%0h, expected no result", b33.out_sum);
            end else begin
                exp_t e;
                e = q33.pop_front();
                chk("sum33", {31'd0, b33.out_sum}, {31'd0, e.sum[32:0]});
                chk("count33", {56'd0, b33.out_count}, {56'd0, e.cnt});
                chk("ovf33", {63'd0, b33.out_ovf}, {63'd0, e.ovf});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One beat on the 64-bit instance; returns 1 ns after the accepting edge.
    task automatic beat(input logic [31:0] d, input logic f);
        b64.in_valid = 1'b1;
        b64.in_data  = d;
        b64.flush    = f;
        cyc();
        b64.in_valid = 1'b0;
        b64.flush    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        b64.in_valid = 1'b0; b64.in_data = '0; b64.len = '0; b64.flush = 1'b0; b64.out_ready = 1'b1;
        b33.in_valid = 1'b0; b33.in_data = '0; b33.len = '0; b33.flush = 1'b0; b33.out_ready = 1'b1;

        // reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, b64.in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, b64.out_valid}, 64'd0);
        chk("rst_out_sum", b64.out_sum, 64'd0);
        chk("rst_out_count", {56'd0, b64.out_count}, 64'd0);
        chk("rst_out_ovf", {63'd0, b64.out_ovf}, 64'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("idle_in_ready", {63'd0, b64.in_ready}, 64'd1);

        // len=4 burst 1,2,3,4
        b64.len = 8'd4;
        q64.push_back('{sum: 64'd10, cnt: 8'd4, ovf: 1'b0});
        for (int unsigned i = 1; i <= 4; i++) beat(32'(i), 1'b0);
        chk("b4_latency_valid", {63'd0, b64.out_valid}, 64'd1);
        chk("b4_done_in_ready", {63'd0, b64.in_ready}, 64'd0);
        cyc();
        chk("b4_post_hs_in_ready", {63'd0, b64.in_ready}, 64'd1);

        // len=0 treated as 1
        b64.len = 8'd0;
        q64.push_back('{sum: 64'hFFFF_FFFF, cnt: 8'd1, ovf: 1'b0});
        beat(32'hFFFF_FFFF, 1'b0);
        chk("len0_valid", {63'd0, b64.out_valid}, 64'd1);
        cyc();
        chk("len0_post_hs_in_ready", {63'd0, b64.in_ready}, 64'd1);

        // flush alone after 5,5,5
        b64.len = 8'd8;
        q64.push_back('{sum: 64'd15, cnt: 8'd3, ovf: 1'b0});
        for (int unsigned i = 0; i < 3; i++) beat(32'd5, 1'b0);
        chk("flush_alone_pending", {63'd0, b64.out_valid}, 64'd0);
        b64.flush = 1'b1;
        cyc();
        b64.flush = 1'b0;
        chk("flush_alone_valid", {63'd0, b64.out_valid}, 64'd1);
        cyc();

        // flush together with third beat
        q64.push_back('{sum: 64'd17, cnt: 8'd3, ovf: 1'b0});
        beat(32'd5, 1'b0);
        beat(32'd5, 1'b0);
        beat(32'd7, 1'b1);
        chk("flush_beat_valid", {63'd0, b64.out_valid}, 64'd1);
        cyc();

        // backpressure in DONE with in_valid held high
        b64.out_ready = 1'b0;
        b64.len = 8'd2;
        q64.push_back('{sum: 64'd30, cnt: 8'd2, ovf: 1'b0});
        beat(32'd10, 1'b0);
        beat(32'd20, 1'b0);
        b64.in_valid = 1'b1;
        b64.in_data  = 32'd99;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {63'd0, b64.in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, b64.out_valid}, 64'd1);
            chk("bp_out_sum", b64.out_sum, 64'd30);
            chk("bp_out_count", {56'd0, b64.out_count}, 64'd2);
            @(posedge clk);
            #1;
        end
        b64.in_valid  = 1'b0;
        b64.out_ready = 1'b1;
        cyc();
        b64.len = 8'd1;
        q64.push_back('{sum: 64'd3, cnt: 8'd1, ovf: 1'b0});
        beat(32'd3, 1'b0);
        cyc();

        // reset mid-burst, then a fresh burst of ones
        b64.len = 8'd4;
        beat(32'd1, 1'b0);
        beat(32'd1, 1'b0);
        rst = 1'b1;
        cyc();
        chk("mid_rst_out_valid", {63'd0, b64.out_valid}, 64'd0);
        chk("mid_rst_out_sum", b64.out_sum, 64'd0);
        chk("mid_rst_out_count", {56'd0, b64.out_count}, 64'd0);
        chk("mid_rst_out_ovf", {63'd0, b64.out_ovf}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, b64.in_ready}, 64'd0);
        rst = 1'b0;
        cyc();
        chk("mid_rst_idle_ready", {63'd0, b64.in_ready}, 64'd1);
        q64.push_back('{sum: 64'd4, cnt: 8'd4, ovf: 1'b0});
        for (int unsigned i = 0; i < 4; i++) beat(32'd1, 1'b0);
        cyc();

        // AW=33 overflow: 3 x 0xFFFF_FFFF wraps to 0x0_FFFF_FFFD
        b33.len = 8'd3;
        q33.push_back('{sum: 64'h0_FFFF_FFFD, cnt: 8'd3, ovf: 1'b1});
        b33.in_valid = 1'b1;
        b33.in_data  = 32'hFFFF_FFFF;
        for (int unsigned i = 0; i < 3; i++) cyc();
        b33.in_valid = 1'b0;
        chk("ovf33_valid", {63'd0, b33.out_valid}, 64'd1);

        // drain: every queued result must have been observed
        for (int unsigned i = 0; i < 20; i++) begin
            if (q64.size() == 0 && q33.size() == 0) break;
            cyc();
        end
        chk("drain_q64", 64'(q64.size()), 64'd0);
        chk("drain_q33", 64'(q33.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
